// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encodings, unit latencies
// and an opcode decode helper used by the issue controller.
package fpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_DIV = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hD;
  localparam logic [3:0] OP_I2F = 4'hE;
  localparam logic [3:0] OP_F2I = 4'hF;

  localparam int FPU_LAT_ADD = 3;
  localparam int FPU_LAT_MUL = 3;
  localparam int FPU_LAT_CMP = 2;
  localparam int FPU_LAT_I2F = 2;
  localparam int FPU_LAT_F2I = 2;
  localparam int FPU_LAT_DIV = 12;

  typedef struct packed {
    logic       legal;
    logic       is_div;
    logic [3:0] lat;
  } op_info_t;

  function automatic op_info_t op_decode(
    input logic [3:0] op
  );
    op_info_t r;
    r = '{legal: 1'b0, is_div: 1'b0, lat: 4'd0};
    unique case (op)
      OP_ADD,
      OP_SUB: r = '{1'b1, 1'b0, 4'(FPU_LAT_ADD)};
      OP_MUL: r = '{1'b1, 1'b0, 4'(FPU_LAT_MUL)};
      OP_DIV: r = '{1'b1, 1'b1, 4'(FPU_LAT_DIV)};
      OP_CMP: r = '{1'b1, 1'b0, 4'(FPU_LAT_CMP)};
      OP_I2F: r = '{1'b1, 1'b0, 4'(FPU_LAT_I2F)};
      OP_F2I: r = '{1'b1, 1'b0, 4'(FPU_LAT_F2I)};
      default: r = '{1'b0, 1'b0, 4'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// Register pending scoreboard: 32 bits of outstanding-result
// state with set/clear ports and a combined RAW/WAW hazard lookup.
// Ports: i_set/i_set_idx mark, i_clr/i_clr_idx release,
// i_dest/i_src_a/i_src_b lookups, o_pending, o_hazard.
module fpu_scoreboard (
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_set,
  input  logic [4:0]  i_set_idx,
  input  logic        i_clr,
  input  logic [4:0]  i_clr_idx,
  input  logic [4:0]  i_dest,
  input  logic [4:0]  i_src_a,
  input  logic [4:0]  i_src_b,
  output logic [31:0] o_pending,
  output logic        o_hazard
);

  logic [31:0] r_pend;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set) w_set[i_set_idx] = 1'b1;
    if (i_clr) w_clr[i_clr_idx] = 1'b1;
    // x0 is hardwired, never outstanding
    w_set[0] = 1'b0;
  end

  // set applied after clear so it wins on a collision
  always_ff @(posedge clock) begin
    if (!resetn) r_pend <= '0;
    else         r_pend <= (r_pend & ~w_clr) | w_set;
  end

  assign o_pending = r_pend;
  assign o_hazard  = r_pend[i_dest]
                   | r_pend[i_src_a]
                   | r_pend[i_src_b];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: hazard checks, write-back slot ring,
// one-cycle registered issue port, illegal-op pulse, stall count.
// Ports: req_* from CPU, fpu_* to/from FPU, reg_pending,
// illegal_op, idle, stall_count.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int SLOT_DEPTH = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_dest,
  input  logic [4:0]  req_src_a,
  input  logic [4:0]  req_src_b,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_in_a,
  output logic [31:0] fpu_in_b,
  output logic [4:0]  fpu_in_dest,
  input  logic        fpu_div_busy,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_dest,
  output logic [31:0] reg_pending,
  output logic        illegal_op,
  output logic        idle,
  output logic [15:0] stall_count
);

  localparam int SW = $clog2(SLOT_DEPTH);

  op_info_t              w_info;
  logic                  w_hazard;
  logic                  w_slot_busy;
  logic                  w_div_block;
  logic                  w_accept;
  logic                  w_issue;
  logic [SW-1:0]         w_lat_idx;
  logic [SW-1:0]         w_res_idx;
  logic [SLOT_DEPTH-1:0] w_slot_nxt;
  logic [SLOT_DEPTH-1:0] r_slot;
  logic                  r_div_issued;

  assign w_info    = op_decode(req_op);
  assign w_lat_idx = SW'(w_info.lat);
  // slot i = result returns i cycles from now;
  // issue adds one cycle before the FPU starts
  assign w_res_idx   = w_lat_idx + SW'(1);
  assign w_slot_busy = r_slot[w_res_idx];

  assign w_div_block = w_info.is_div
                     & (fpu_div_busy | r_div_issued);

  // illegal ops are consumed regardless of hazards
  assign req_ready = resetn
                   & (~w_info.legal
                      | ~(w_hazard | w_slot_busy | w_div_block));

  assign w_accept = req_valid & req_ready;
  assign w_issue  = w_accept & w_info.legal;

  // after the shift, offset L+1 lands on index L
  always_comb begin
    w_slot_nxt = {1'b0, r_slot[SLOT_DEPTH-1:1]};
    if (w_issue) w_slot_nxt[w_lat_idx] = 1'b1;
  end

  fpu_scoreboard u_sb (
    .clock     (clock),
    .resetn    (resetn),
    .i_set     (w_issue),
    .i_set_idx (req_dest),
    .i_clr     (fpu_valid),
    .i_clr_idx (fpu_dest),
    .i_dest    (req_dest),
    .i_src_a   (req_src_a),
    .i_src_b   (req_src_b),
    .o_pending (reg_pending),
    .o_hazard  (w_hazard)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_slot       <= '0;
      r_div_issued <= 1'b0;
      fpu_op       <= 4'h0;
      fpu_in_a     <= '0;
      fpu_in_b     <= '0;
      fpu_in_dest  <= '0;
      illegal_op   <= 1'b0;
      stall_count  <= '0;
    end else begin
      r_slot       <= w_slot_nxt;
      r_div_issued <= w_issue & w_info.is_div;
      fpu_op       <= w_issue ? req_op : 4'h0;
      illegal_op   <= w_accept & ~w_info.legal;
      if (w_issue) begin
        fpu_in_a    <= req_a;
        fpu_in_b    <= req_b;
        fpu_in_dest <= req_dest;
      end
      if (req_valid && !req_ready
          && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

  assign idle = ~resetn
              | ((reg_pending == '0) && (r_slot == '0));

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: opcode table,
// directed hazard/div/illegal/reset sequences, issue scoreboard.
module tb_fpu_issue_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_dest;
  logic [4:0]  req_src_a;
  logic [4:0]  req_src_b;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_in_a;
  logic [31:0] fpu_in_b;
  logic [4:0]  fpu_in_dest;
  logic        fpu_div_busy;
  logic [31:0] reg_pending;
  logic        illegal_op;
  logic        idle;
  logic [15:0] stall_count;

  logic       man_v;
  logic [4:0] man_d;
  logic       auto_en;
  logic       auto_v = 1'b0;
  logic [4:0] auto_d = 5'd0;
  wire        fv_w = auto_v | man_v;
  wire  [4:0] fd_w = auto_v ? auto_d : man_d;

  logic cur_lg;
  int   cur_lat;

  int pass_cnt = 0;
  int total_cnt = 0;

  fpu_issue_ctrl #(.SLOT_DEPTH(16)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_dest     (req_dest),
    .req_src_a    (req_src_a),
    .req_src_b    (req_src_b),
    .fpu_op       (fpu_op),
    .fpu_in_a     (fpu_in_a),
    .fpu_in_b     (fpu_in_b),
    .fpu_in_dest  (fpu_in_dest),
    .fpu_div_busy (fpu_div_busy),
    .fpu_valid    (fv_w),
    .fpu_dest     (fd_w),
    .reg_pending  (reg_pending),
    .illegal_op   (illegal_op),
    .idle         (idle),
    .stall_count  (stall_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ---------------- issue scoreboard / model ----------------
  typedef struct {
    logic        lg;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    int          lat;
  } iss_t;

  typedef struct {
    int         ret;
    logic [4:0] d;
  } ret_t;

  iss_t isq[$];
  ret_t rq[$];
  iss_t it;
  int          cyc = 0;
  logic [31:0] e_pend = '0;
  logic [15:0] e_stall = '0;
  logic [3:0]  e_op;
  logic        e_ill;
  logic        s_rst = 1'b0;
  logic        s_vld = 1'b0;
  logic        s_acc = 1'b0;
  logic        s_fv = 1'b0;
  logic [4:0]  s_fd = 5'd0;

  always @(negedge clock) begin
    s_rst = resetn;
    s_vld = req_valid;
    s_acc = req_valid && req_ready;
    s_fv  = fv_w;
    s_fd  = fd_w;
    if (s_acc)
      isq.push_back('{cur_lg, req_op, req_a, req_b,
                      req_dest, cur_lat});
  end

  always @(posedge clock) begin
    #1;
    cyc++;
    e_op  = 4'h0;
    e_ill = 1'b0;
    if (!s_rst) begin
      isq.delete();
      rq.delete();
      e_pend  = '0;
      e_stall = '0;
    end else begin
      if (s_vld && !s_acc && e_stall != 16'hFFFF)
        e_stall++;
      if (s_fv) e_pend[s_fd] = 1'b0;
      if (isq.size() > 0) begin
        it = isq.pop_front();
        if (it.lg) begin
          e_op = it.op;
          chk("fpu_in_a", fpu_in_a, it.a);
          chk("fpu_in_b", fpu_in_b, it.b);
          chk("fpu_in_dest", 32'(fpu_in_dest), 32'(it.d));
          if (it.d != 5'd0) e_pend[it.d] = 1'b1;
          rq.push_back('{cyc + it.lat, it.d});
        end else begin
          e_ill = 1'b1;
        end
      end
    end
    chk("fpu_op", 32'(fpu_op), 32'(e_op));
    chk("illegal_op", 32'(illegal_op), 32'(e_ill));
    chk("reg_pending", reg_pending, e_pend);
    chk("stall_count", 32'(stall_count), 32'(e_stall));
    for (int k = rq.size() - 1; k >= 0; k--)
      if (rq[k].ret < cyc) rq.delete(k);
    chk("idle", 32'(idle),
        32'((e_pend == '0) && (rq.size() == 0)));
    auto_v = 1'b0;
    foreach (rq[k])
      if (auto_en && rq[k].ret == cyc) begin
        auto_v = 1'b1;
        auto_d = rq[k].d;
      end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic offer(input logic [3:0] op,
                       input logic [4:0] d,
                       input logic [4:0] sa,
                       input logic [4:0] sb,
                       input logic lg,
                       input int lat,
                       input logic rdy,
                       input string nm);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = $urandom;
    req_b     = $urandom;
    req_dest  = d;
    req_src_a = sa;
    req_src_b = sb;
    cur_lg    = lg;
    cur_lat   = lat;
    @(negedge clock);
    chk(nm, 32'(req_ready), 32'(rdy));
    @(posedge clock);
    #2;
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [4:0] d;
    logic       lg;
    int         lat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{4'h0, 5'd1,  1'b0, 0};
    tbl[1]  = '{4'h1, 5'd1,  1'b0, 0};
    tbl[2]  = '{4'h2, 5'd2,  1'b0, 0};
    tbl[3]  = '{4'h3, 5'd3,  1'b0, 0};
    tbl[4]  = '{4'h4, 5'd4,  1'b0, 0};
    tbl[5]  = '{4'h5, 5'd5,  1'b0, 0};
    tbl[6]  = '{4'h6, 5'd6,  1'b0, 0};
    tbl[7]  = '{4'h7, 5'd7,  1'b0, 0};
    tbl[8]  = '{4'h8, 5'd0,  1'b1, 3};
    tbl[9]  = '{4'h9, 5'd2,  1'b1, 3};
    tbl[10] = '{4'hA, 5'd3,  1'b1, 3};
    tbl[11] = '{4'hB, 5'd31, 1'b1, 12};
    tbl[12] = '{4'hC, 5'd8,  1'b0, 0};
    tbl[13] = '{4'hD, 5'd5,  1'b1, 2};
    tbl[14] = '{4'hE, 5'd6,  1'b1, 2};
    tbl[15] = '{4'hF, 5'd7,  1'b1, 2};

    resetn       = 1'b0;
    req_valid    = 1'b1;
    req_op       = 4'h8;
    req_a        = '0;
    req_b        = '0;
    req_dest     = 5'd1;
    req_src_a    = '0;
    req_src_b    = '0;
    fpu_div_busy = 1'b0;
    man_v        = 1'b0;
    man_d        = '0;
    auto_en      = 1'b1;
    cur_lg       = 1'b1;
    cur_lat      = 3;

    @(negedge clock);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    tick(2);
    resetn    = 1'b1;
    req_valid = 1'b0;
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_pending", reg_pending, 32'd0);

    foreach (tbl[i]) begin
      offer(tbl[i].op, tbl[i].d,
            5'($urandom_range(31)),
            5'($urandom_range(31)),
            tbl[i].lg, tbl[i].lat, 1'b1,
            $sformatf("vec%0d_ready", i));
      tick(15);
    end

    // add r3, manual write-back at cycle 4
    auto_en = 1'b0;
    offer(4'h8, 5'd3, 5'd0, 5'd0, 1'b1, 3, 1'b1, "add_r3");
    chk("add_r3_op", 32'(fpu_op), 32'h8);
    chk("add_r3_pend", 32'(reg_pending[3]), 32'd1);
    tick(3);
    man_v = 1'b1;
    man_d = 5'd3;
    tick(1);
    man_v = 1'b0;
    chk("add_r3_clr", reg_pending, 32'd0);
    chk("add_r3_idle", 32'(idle), 32'd1);
    auto_en = 1'b1;
    tick(4);

    // slot collision: cmp wants the slot mul holds
    offer(4'hA, 5'd5, 5'd0, 5'd0, 1'b1, 3, 1'b1, "mul_r5");
    offer(4'hD, 5'd7, 5'd0, 5'd0, 1'b1, 2, 1'b0, "cmp_slot_stall");
    offer(4'hD, 5'd7, 5'd0, 5'd0, 1'b1, 2, 1'b1, "cmp_slot_go");
    chk("stall_one", 32'(stall_count), 32'd1);
    tick(16);
    offer(4'hA, 5'd5, 5'd0, 5'd0, 1'b1, 3, 1'b1, "mul_r5_b");
    offer(4'h8, 5'd6, 5'd0, 5'd0, 1'b1, 3, 1'b1, "add_r6_ok");
    tick(16);

    // RAW on r4 until the cycle after its write-back
    auto_en = 1'b0;
    offer(4'h8, 5'd4, 5'd0, 5'd0, 1'b1, 3, 1'b1, "add_r4");
    offer(4'h9, 5'd9, 5'd4, 5'd0, 1'b1, 3, 1'b0, "raw_c1");
    offer(4'h9, 5'd9, 5'd4, 5'd0, 1'b1, 3, 1'b0, "raw_c2");
    offer(4'h9, 5'd9, 5'd4, 5'd0, 1'b1, 3, 1'b0, "raw_c3");
    man_v = 1'b1;
    man_d = 5'd4;
    offer(4'h9, 5'd9, 5'd4, 5'd0, 1'b1, 3, 1'b0, "raw_c4");
    man_v   = 1'b0;
    auto_en = 1'b1;
    offer(4'h9, 5'd9, 5'd4, 5'd0, 1'b1, 3, 1'b1, "raw_c5");
    tick(16);

    // back-to-back div, then div busy
    offer(4'hB, 5'd10, 5'd0, 5'd0, 1'b1, 12, 1'b1, "divA");
    offer(4'hB, 5'd11, 5'd0, 5'd0, 1'b1, 12, 1'b0, "div_b2b");
    offer(4'hB, 5'd11, 5'd0, 5'd0, 1'b1, 12, 1'b1, "divB");
    tick(20);
    offer(4'hB, 5'd10, 5'd0, 5'd0, 1'b1, 12, 1'b1, "div1");
    fpu_div_busy = 1'b1;
    offer(4'hB, 5'd11, 5'd0, 5'd0, 1'b1, 12, 1'b0, "div_busy1");
    offer(4'hB, 5'd11, 5'd0, 5'd0, 1'b1, 12, 1'b0, "div_busy2");
    offer(4'hB, 5'd11, 5'd0, 5'd0, 1'b1, 12, 1'b0, "div_busy3");
    fpu_div_busy = 1'b0;
    offer(4'hB, 5'd11, 5'd0, 5'd0, 1'b1, 12, 1'b1, "div_free");
    tick(20);

    // illegal op ignores hazards and leaves scoreboard alone
    offer(4'h8, 5'd12, 5'd0, 5'd0, 1'b1, 3, 1'b1, "add_r12");
    offer(4'h3, 5'd12, 5'd12, 5'd12, 1'b0, 0, 1'b1, "ill_ready");
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_no_issue", 32'(fpu_op), 32'd0);
    chk("ill_pend", reg_pending, 32'h0000_1000);
    offer(4'h9, 5'd12, 5'd0, 5'd0, 1'b1, 3, 1'b0, "waw_r12");
    tick(16);

    // reset with three ops in flight
    auto_en = 1'b0;
    offer(4'h8, 5'd1, 5'd0, 5'd0, 1'b1, 3, 1'b1, "fl_add");
    offer(4'hA, 5'd2, 5'd0, 5'd0, 1'b1, 3, 1'b1, "fl_mul");
    offer(4'hB, 5'd3, 5'd0, 5'd0, 1'b1, 12, 1'b1, "fl_div");
    offer(4'h9, 5'd4, 5'd1, 5'd0, 1'b1, 3, 1'b0, "fl_stall");
    resetn = 1'b0;
    offer(4'h8, 5'd5, 5'd0, 5'd0, 1'b1, 3, 1'b0, "fl_rst_rdy");
    resetn = 1'b1;
    chk("fl_pend", reg_pending, 32'd0);
    chk("fl_idle", 32'(idle), 32'd1);
    chk("fl_stall_cnt", 32'(stall_count), 32'd0);
    chk("fl_op", 32'(fpu_op), 32'd0);
    for (int r = 1; r <= 3; r++) begin
      man_v = 1'b1;
      man_d = 5'(r);
      tick(1);
    end
    man_v = 1'b0;
    tick(2);
    chk("late_pend", reg_pending, 32'd0);
    chk("late_idle", 32'(idle), 32'd1);
    auto_en = 1'b1;
    tick(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter SLOT_DEPTH, default 16: length of the write-back slot reservation ring; it must exceed FPU_LAT_DIV+1.
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: the CPU offers an FPU operation.
REQ-005 SHALL have port req_ready, output, 1: the operation is accepted this cycle (combinational).
REQ-006 SHALL have ports req_op (4), req_a (32), req_b (32), req_dest (5), req_src_a (5), req_src_b (5), all input: opcode, operands, destination register and source register indices.
REQ-007 SHALL have ports fpu_op (4), fpu_in_a (32), fpu_in_b (32), fpu_in_dest (5), all output and registered: the issue port to the FPU.
REQ-008 SHALL have ports fpu_div_busy, fpu_valid (1 each) and fpu_dest (5), all input: FPU divider busy, result valid, and result destination.
REQ-009 SHALL have port reg_pending, output, 32: scoreboard with one bit per register that has a result outstanding.
REQ-010 SHALL have port illegal_op, output, 1: one-cycle pulse when an unsupported opcode is consumed.
REQ-011 SHALL have port idle, output, 1: no result outstanding and no slot reserved.
REQ-012 SHALL have port stall_count, output, 16: saturating count of cycles with req_valid=1 and req_ready=0.

Function
REQ-013 Legal opcodes SHALL be 8 add, 9 sub, A mul, B div, D cmp, E i2f, F f2i; all other opcodes are illegal.
REQ-014 Latencies from fpu_op being presented to fpu_valid SHALL be: add/sub 3, mul 3, cmp 2, i2f 2, f2i 2, div 12.
REQ-015 Issue latency SHALL be 1: a request accepted in cycle N drives fpu_op/fpu_in_* in cycle N+1 for exactly one cycle; in every other cycle fpu_op=0.
REQ-016 A legal request SHALL be accepted only when all of these hold: reg_pending[req_dest]=0, reg_pending[req_src_a]=0, reg_pending[req_src_b]=0, and the write-back slot at offset L+1 is free (L is the opcode latency).
REQ-017 A div request SHALL additionally need fpu_div_busy=0 and no div accepted in the previous cycle.
REQ-018 Illegal requests SHALL be accepted unconditionally, pulse illegal_op in the next cycle, issue nothing and reserve nothing.
REQ-019 The slot ring SHALL shift by one position per cycle; on accept, slot L+1 is set, so no two results ever reach fpu_valid in the same cycle.
REQ-020 On accept with req_dest≠0, reg_pending[req_dest] SHALL be set from the next cycle; register 0 is never marked pending.
REQ-021 fpu_valid=1 SHALL clear reg_pending[fpu_dest] at the next edge; if a set and a clear target the same register in one cycle, the set SHALL win.
REQ-022 idle SHALL be 1 when reg_pending==0 and all slots are free.
REQ-023 stall_count SHALL hold at 16'hFFFF once it reaches that value.

Reset
REQ-024 While resetn=0 at an edge, the block SHALL clear fpu_op, fpu_in_a, fpu_in_b, fpu_in_dest, reg_pending, the slot ring, the div-issued flag, illegal_op and stall_count, and SHALL drive idle=1.
REQ-025 req_ready SHALL be 0 during reset.
REQ-026 fpu_valid arriving after a reset issued mid-operation SHALL clear only bits that are already 0, with no other effect.

Structure
REQ-027 A shared package fpu_pkg SHALL hold the opcode constants and FPU_LAT_* latency constants, which the FPU units also use.
REQ-028 The block SHALL instantiate one sub-module, fpu_scoreboard, containing the 32-bit pending set/clear logic and the hazard lookups.

Verification
REQ-029 After reset, add r3 accepted at cycle 0 SHALL give fpu_op=8, dest 3 at cycle 1; reg_pending[3]=1; an injected fpu_valid at cycle 4 with dest 3 SHALL make reg_pending=0 and idle=1 at cycle 5.
REQ-030 mul r5 accepted at cycle 0, then add r6 offered at cycle 0... SHALL be accepted at cycle 1 only if the slots differ; cmp r7 offered at cycle 1 (slot 3, which mul holds) SHALL stall one cycle, and stall_count SHALL become 1.
REQ-031 add r4 pending, then a request with req_src_a=4 SHALL keep req_ready=0 until the cycle after fpu_valid for dest 4.
REQ-032 Two back-to-back div requests SHALL accept the first and block the second while fpu_div_busy=1.
REQ-033 req_op=4'h3 SHALL give req_ready=1, an illegal_op pulse, fpu_op=0, and no change to reg_pending.
REQ-034 resetn=0 asserted while 3 ops are in flight SHALL give reg_pending=0, idle=1 and stall_count=0 after the edge, and later fpu_valid pulses SHALL be harmless.
